// File: rtl/cbs_pkg.sv
// rtl/cbs_pkg.sv - shared constants and stage record for the pipelined borrow-bypass subtractor
package cbs_pkg;

    localparam int DATA_W    = 16;
    localparam int DEF_BLK_W = 4;
    localparam int NUM_STG   = DATA_W / DEF_BLK_W;

    // Operands travel whole; diff fills in one block per stage.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] diff;
        logic              borrow;
    } stage_t;

endpackage

// File: rtl/cbs_block.sv
// rtl/cbs_block.sv - one borrow-bypass block: ripple borrow chain with equal-bits bypass mux
module cbs_block #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0]   br;
    logic [W-1:0] eq;

    always_comb begin
        br[0] = bin;
        eq    = '0;
        d     = '0;
        for (int i = 0; i < W; i++) begin
            eq[i]    = ~(a[i] ^ b[i]);
            d[i]     = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (eq[i] & br[i]);
        end
    end

    // When every bit pair matches the ripple chain just propagates bin.
    assign bout = (&eq) ? bin : br[W];

endmodule

// File: rtl/carry_bypass_sub16_pipe.sv
// rtl/carry_bypass_sub16_pipe.sv - 16-bit pipelined borrow-bypass subtractor; optional ovf port under CBS_OVERFLOW_EN
module carry_bypass_sub16_pipe
    import cbs_pkg::*;
#(
    parameter int BLK_W = DEF_BLK_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout
`ifdef CBS_OVERFLOW_EN
    ,
    output logic        ovf
`endif
);

    localparam int NSTG = DATA_W / BLK_W;

    stage_t           st     [NSTG];
    stage_t           src    [NSTG];
    stage_t           nxt    [NSTG];
    logic [BLK_W-1:0] blk_d  [NSTG];
    logic [NSTG-1:0]  blk_bo;
    logic [NSTG-1:0]  ld;

    // A stage may load if it or any stage downstream of it has room, or the sink takes the result.
    always_comb begin
        logic acc;
        acc = out_ready;
        ld  = '0;
        for (int s = NSTG - 1; s >= 0; s--) begin
            acc   = acc | ~st[s].valid;
            ld[s] = acc;
        end
    end

    assign in_ready = ld[0];

    always_comb begin
        src[0].valid  = in_valid;
        src[0].a      = a;
        src[0].b      = b;
        src[0].diff   = '0;
        src[0].borrow = bin;
        for (int s = 1; s < NSTG; s++) begin
            src[s] = st[s-1];
        end
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_blk
        cbs_block #(.W(BLK_W)) u_blk (
            .a    (src[s].a[s*BLK_W +: BLK_W]),
            .b    (src[s].b[s*BLK_W +: BLK_W]),
            .bin  (src[s].borrow),
            .d    (blk_d[s]),
            .bout (blk_bo[s])
        );
    end

    always_comb begin
        for (int s = 0; s < NSTG; s++) begin
            nxt[s]                        = src[s];
            nxt[s].valid                  = 1'b1;
            nxt[s].diff[s*BLK_W +: BLK_W] = blk_d[s];
            nxt[s].borrow                 = blk_bo[s];
        end
    end

    // Bubbles only clear valid so the held payload does not toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSTG; s++) begin
                st[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                if (ld[s] && src[s].valid) begin
                    st[s] <= nxt[s];
                end else if (ld[s]) begin
                    st[s].valid <= 1'b0;
                end
            end
        end
    end

`ifdef CBS_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ld[NSTG-1] && src[NSTG-1].valid) begin
            ovf <= (src[NSTG-1].a[DATA_W-1] != src[NSTG-1].b[DATA_W-1]) &&
                   (nxt[NSTG-1].diff[DATA_W-1] != src[NSTG-1].a[DATA_W-1]);
        end
    end
`endif

    assign out_valid = st[NSTG-1].valid;
    assign diff      = st[NSTG-1].diff;
    assign bout      = st[NSTG-1].borrow;

endmodule

// File: tb/tb_carry_bypass_sub16_pipe.sv
// tb/tb_carry_bypass_sub16_pipe.sv - self-checking bench for carry_bypass_sub16_pipe (default BLK_W=4)
module tb_carry_bypass_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
`ifdef CBS_OVERFLOW_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    carry_bypass_sub16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CBS_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    vec_t        vecs [8];
    int          total = 0;
    int          bad   = 0;
    logic [16:0] expq [$];
    int          sent;
    int          got;
    int          acc_at_drop;
    int          low_cnt;
    int          r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {16'b0, c};
    endfunction

    task automatic send_one(input vec_t v);
        @(negedge clk);
        a         = v.a;
        b         = v.b;
        bin       = v.bin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check("acc_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'h5555;
        b        = 16'haaaa;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("early_valid", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("diff", {16'b0, diff}, {16'b0, v.d});
        check("bout", {31'b0, bout}, {31'b0, v.bo});
`ifdef CBS_OVERFLOW_EN
        check("ovf", {31'b0, ovf}, {31'b0, v.ov});
`endif
        @(negedge clk);
        check("drained", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hffff, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7fff, 1'b0, 1'b1};
        vecs[3] = '{16'habcd, 16'habcd, 1'b1, 16'hffff, 1'b1, 1'b0};
        vecs[4] = '{16'hffff, 16'h0000, 1'b1, 16'hfffe, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0007, 1'b0, 16'hfffe, 1'b1, 1'b0};
        vecs[6] = '{16'h7fff, 16'hffff, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[7] = '{16'h00f0, 16'h00f0, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'h0;
        b         = 16'h0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_diff", {16'b0, diff}, 32'd0);
        check("rst_bout", {31'b0, bout}, 32'd0);
        rst = 1'b0;
        #1 check("rst_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i]);
        end

        // 8 back-to-back beats with the sink stalled for cycles 3..9
        sent        = 0;
        got         = 0;
        acc_at_drop = -1;
        low_cnt     = 0;
        expq.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            a         = 16'h3000 + 16'(sent) * 16'h0123;
            b         = 16'h1111 * 16'(sent);
            bin       = sent[0];
            out_ready = !(cyc >= 3 && cyc <= 9);
            #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("stall_extra", 32'd1, 32'd0);
                end else begin
                    check("stall_data", {15'b0, bout, diff}, {15'b0, expq[0]});
                    if (out_ready) begin
                        void'(expq.pop_front());
                        got++;
                    end
                end
            end
            if (!in_ready) begin
                low_cnt++;
                if (acc_at_drop < 0) acc_at_drop = sent;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_sub(a, b, bin));
                sent++;
            end
        end
        check("stall_drop_at", acc_at_drop, 32'd4);
        check("stall_low_cycles", low_cnt, 32'd6);
        check("stall_emitted", got, 32'd8);

        // random traffic with a reset pulse in the middle
        expq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500) begin
                rst = 1'b1;
                #1;
                check("midrst_valid", {31'b0, out_valid}, 32'd0);
                check("midrst_diff", {16'b0, diff}, 32'd0);
                expq.delete();
            end
            if (cyc == 1503) rst = 1'b0;
            in_valid = ($urandom_range(0, 3) != 0);
            a        = 16'($urandom);
            r        = int'($urandom_range(0, 3));
            if (r == 0)      b = a;
            else if (r == 1) b = a ^ (16'h1 << $urandom_range(0, 15));
            else             b = 16'($urandom);
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) check("rnd_stale", 32'd1, 32'd0);
                    else check("rnd_data", {15'b0, bout, diff}, {15'b0, expq.pop_front()});
                end
                if (in_valid && in_ready) expq.push_back(ref_sub(a, b, bin));
            end
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (expq.size() == 0) check("rnd_stale", 32'd1, 32'd0);
                else check("rnd_data", {15'b0, bout, diff}, {15'b0, expq.pop_front()});
            end
        end
        check("rnd_left", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
